// File: rtl/uart_tx_frame_serializer_if.sv
// Parallel-side request bundle and serial-side outputs of the UART transmitter.
// The master drives the word and frame options; the slave returns the serial line and busy.
interface uart_tx_frame_serializer_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
);
    logic [DATA_WIDTH-1:0]     P_DATA;
    logic                      Data_Valid;
    logic                      PAR_EN;
    logic                      PAR_TYP;
    logic [PRESCALE_WIDTH-1:0] Prescale;
    logic                      TX_OUT;
    logic                      busy;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
        input  TX_OUT, busy
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
        output TX_OUT, busy
    );
endinterface

// File: rtl/uart_tx_frame_serializer.sv
// UART transmitter: start bit, LSB-first data, optional even/odd parity, stop bit.
// Every bit lasts Prescale clocks; the frame options are frozen when the word is accepted.
module uart_tx_frame_serializer #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                           CLK,
    input  logic                           RST,
    uart_tx_frame_serializer_if.slave      tx_if
);
    localparam int BIT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                    state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic [BIT_W-1:0]          bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic [DATA_WIDTH-1:0]     shift_q, shift_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic                      par_en_q, par_en_d;
    logic                      par_typ_q, par_typ_d;
    logic                      tx_out_q, tx_out_d;
    logic                      busy_q, busy_d;
    logic                      bit_done;

    assign bit_done = (edge_cnt_q == prescale_q - PRESCALE_WIDTH'(1));

    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        data_d     = data_q;
        shift_d    = shift_q;
        prescale_d = prescale_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        tx_out_d   = tx_out_q;
        busy_d     = busy_q;

        if (state_q == IDLE) begin
            if (tx_if.Data_Valid) begin
                state_d    = START;
                data_d     = tx_if.P_DATA;
                shift_d    = tx_if.P_DATA;
                par_en_d   = tx_if.PAR_EN;
                par_typ_d  = tx_if.PAR_TYP;
                prescale_d = (tx_if.Prescale == '0) ? PRESCALE_WIDTH'(1) : tx_if.Prescale;
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
                tx_out_d   = 1'b0;
                busy_d     = 1'b1;
            end
        end else if (!bit_done) begin
            edge_cnt_d = edge_cnt_q + PRESCALE_WIDTH'(1);
        end else begin
            // Bit boundary: the line only ever changes here, which keeps TX_OUT glitch-free.
            edge_cnt_d = '0;
            case (state_q)
                START: begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    tx_out_d  = shift_q[0];
                    shift_d   = shift_q >> 1;
                end
                DATA: begin
                    if (bit_cnt_q == LAST_BIT) begin
                        if (par_en_q) begin
                            state_d  = PARITY;
                            tx_out_d = par_typ_q ? ~^data_q : ^data_q;
                        end else begin
                            state_d  = STOP;
                            tx_out_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        tx_out_d  = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end
                PARITY: begin
                    state_d  = STOP;
                    tx_out_d = 1'b1;
                end
                STOP: begin
                    state_d  = IDLE;
                    tx_out_d = 1'b1;
                    busy_d   = 1'b0;
                end
                default: begin
                    state_d  = IDLE;
                    tx_out_d = 1'b1;
                    busy_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            data_q     <= '0;
            shift_q    <= '0;
            prescale_q <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            tx_out_q   <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            data_q     <= data_d;
            shift_q    <= shift_d;
            prescale_q <= prescale_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            tx_out_q   <= tx_out_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_if.TX_OUT = tx_out_q;
    assign tx_if.busy   = busy_q;
endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// Directed bench for uart_tx_frame_serializer: a table of single frames with hand-computed
// bit patterns, plus hand-written sequences for mid-frame requests, back-to-back frames and reset.
module tb_uart_tx_frame_serializer;
    localparam int MAXC = 300;

    typedef struct {
        logic [7:0]  data;
        logic        par_en;
        logic        par_typ;
        logic [5:0]  prescale;
        int          p_eff;
        int          nbits;
        logic [11:0] bits;
        int          cycles;
    } vec_t;

    logic CLK = 1'b0;
    logic RST;
    int   n_compared = 0;
    int   n_mismatch = 0;
    logic tx_log   [0:MAXC-1];
    logic busy_log [0:MAXC-1];
    vec_t vecs [0:6];

    uart_tx_frame_serializer_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) tx_if ();

    uart_tx_frame_serializer #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .tx_if (tx_if.slave)
    );

    always #5 CLK = ~CLK;

    task automatic compare(input string name, input int actual, input int expected);
        n_compared++;
        if (actual != expected) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic pe, input logic pt,
                                 input logic [5:0] ps);
        tx_if.P_DATA     = d;
        tx_if.PAR_EN     = pe;
        tx_if.PAR_TYP    = pt;
        tx_if.Prescale   = ps;
        tx_if.Data_Valid = 1'b1;
    endtask

    // Logs one sample per cycle from the accept edge until the first busy=0 sample.
    task automatic captureFrame(input bit release_dv, output int n);
        bit done;
        n    = 0;
        done = 1'b0;
        while (!done && n < MAXC) begin
            @(posedge CLK); #1;
            tx_log[n]   = tx_if.TX_OUT;
            busy_log[n] = tx_if.busy;
            if (n == 0 && release_dv) begin
                tx_if.Data_Valid = 1'b0;
                tx_if.P_DATA     = ~tx_if.P_DATA;
                tx_if.PAR_EN     = ~tx_if.PAR_EN;
                tx_if.PAR_TYP    = ~tx_if.PAR_TYP;
                tx_if.Prescale   = tx_if.Prescale + 6'd5;
            end
            if (!tx_if.busy) done = 1'b1;
            n++;
        end
        compare("capture_done", int'(done), 1);
    endtask

    task automatic checkOutput(input string tag, input int n, input logic [11:0] bits,
                               input int nbits, input int p, input int cycles);
        compare({tag, " busy_len"}, n - 1, cycles);
        for (int i = 0; i < nbits; i++) begin
            int got;
            got = int'(bits[i]);
            for (int k = i * p; k < i * p + p; k++) begin
                if (k >= n - 1) begin
                    got = 9;
                    break;
                end
                if (tx_log[k] !== bits[i]) begin
                    got = int'(tx_log[k]);
                    break;
                end
            end
            compare($sformatf("%s bit%0d", tag, i), got, int'(bits[i]));
        end
        compare({tag, " idle_tx"}, int'(tx_log[n-1]), 1);
        compare({tag, " idle_busy"}, int'(busy_log[n-1]), 0);
    endtask

    initial begin
        int n;
        int bad;
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 6'd8,  8,  10, {2'b00, 1'b1, 8'hA5, 1'b0}, 80};
        vecs[1] = '{8'h07, 1'b1, 1'b0, 6'd16, 16, 11, {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 176};
        vecs[2] = '{8'h07, 1'b1, 1'b1, 6'd16, 16, 11, {1'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 176};
        vecs[3] = '{8'h00, 1'b0, 1'b0, 6'd0,  1,  10, {2'b00, 1'b1, 8'h00, 1'b0}, 10};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 6'd3,  3,  11, {1'b0, 1'b1, 1'b1, 8'hFF, 1'b0}, 33};
        vecs[5] = '{8'h3C, 1'b1, 1'b0, 6'd2,  2,  11, {1'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 22};
        vecs[6] = '{8'h80, 1'b0, 1'b1, 6'd1,  1,  10, {2'b00, 1'b1, 8'h80, 1'b0}, 10};

        RST              = 1'b1;
        tx_if.Data_Valid = 1'b0;
        tx_if.P_DATA     = '0;
        tx_if.PAR_EN     = 1'b0;
        tx_if.PAR_TYP    = 1'b0;
        tx_if.Prescale   = 6'd8;

        $display("[TB] reset and idle");
        for (int c = 0; c < 7; c++) begin
            @(posedge CLK); #1;
            if (c == 1) RST = 1'b0;
            compare($sformatf("reset_idle_tx c%0d", c), int'(tx_if.TX_OUT), 1);
            compare($sformatf("reset_idle_busy c%0d", c), int'(tx_if.busy), 0);
        end

        $display("[TB] table of single frames");
        for (int v = 0; v < 7; v++) begin
            applyStimulus(vecs[v].data, vecs[v].par_en, vecs[v].par_typ, vecs[v].prescale);
            captureFrame(1'b1, n);
            checkOutput($sformatf("vec%0d", v), n, vecs[v].bits, vecs[v].nbits,
                        vecs[v].p_eff, vecs[v].cycles);
            repeat (2) @(posedge CLK);
            #1;
        end

        $display("[TB] request while busy is dropped");
        applyStimulus(8'h3C, 1'b0, 1'b0, 6'd4);
        fork
            captureFrame(1'b1, n);
            begin
                repeat (15) @(posedge CLK);
                #2;
                tx_if.P_DATA     = 8'hFF;
                tx_if.PAR_EN     = 1'b0;
                tx_if.Prescale   = 6'd4;
                tx_if.Data_Valid = 1'b1;
                @(posedge CLK); #2;
                tx_if.Data_Valid = 1'b0;
            end
        join
        checkOutput("busy_drop", n, {2'b00, 1'b1, 8'h3C, 1'b0}, 10, 4, 40);
        bad = 0;
        repeat (12) begin
            @(posedge CLK); #1;
            if (tx_if.busy !== 1'b0 || tx_if.TX_OUT !== 1'b1) bad++;
        end
        compare("busy_drop no_extra_frame", bad, 0);

        $display("[TB] Data_Valid held high, back-to-back frames");
        applyStimulus(8'h11, 1'b0, 1'b0, 6'd4);
        fork
            captureFrame(1'b0, n);
            begin
                repeat (10) @(posedge CLK);
                #2;
                tx_if.P_DATA = 8'h22;
            end
        join
        checkOutput("b2b frame1", n, {2'b00, 1'b1, 8'h11, 1'b0}, 10, 4, 40);
        captureFrame(1'b1, n);
        compare("b2b single_gap", int'(busy_log[0]), 1);
        checkOutput("b2b frame2", n, {2'b00, 1'b1, 8'h22, 1'b0}, 10, 4, 40);
        repeat (2) @(posedge CLK);
        #1;

        $display("[TB] reset during data bit 3");
        applyStimulus(8'h96, 1'b0, 1'b0, 6'd8);
        for (int k = 0; k < 35; k++) begin
            @(posedge CLK); #1;
            if (k == 0) tx_if.Data_Valid = 1'b0;
        end
        compare("rst_mid busy_before", int'(tx_if.busy), 1);
        compare("rst_mid bit3", int'(tx_if.TX_OUT), 0);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        compare("rst_mid tx_after", int'(tx_if.TX_OUT), 1);
        compare("rst_mid busy_after", int'(tx_if.busy), 0);
        @(posedge CLK); #1;
        compare("rst_mid no_resume", int'(tx_if.busy), 0);
        applyStimulus(8'h5A, 1'b1, 1'b0, 6'd5);
        captureFrame(1'b1, n);
        checkOutput("rst_mid next", n, {1'b0, 1'b1, 1'b0, 8'h5A, 1'b0}, 11, 5, 55);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end
endmodule
